// File: rtl/alu_pkg.sv
// Shared ALU op codes, sequencer state and decode helpers for the execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_NOR = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_XOR = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > ALU_XOR;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider on one 2*WIDTH accumulator.
// The load cycle also performs the first step, so WIDTH-1 further steps finish.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc_q, acc_d, src;
  logic [WIDTH-1:0]   b_q, bsel;
  logic               div_q, dsel;
  logic [WIDTH:0]     sum, rem_sh, diff;

  always_comb begin
    src    = start ? {{WIDTH{1'b0}}, a} : acc_q;
    bsel   = start ? b : b_q;
    dsel   = start ? is_div : div_q;
    sum    = {1'b0, src[2*WIDTH-1:WIDTH]} + {1'b0, bsel};
    rem_sh = {src[2*WIDTH-1:WIDTH], src[WIDTH-1]};
    diff   = rem_sh - {1'b0, bsel};
    acc_d  = acc_q;
    if (dsel) begin
      // borrow out of diff means the shifted remainder was below the divisor
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], src[WIDTH-2:0], 1'b1};
      else              acc_d = {rem_sh[WIDTH-1:0], src[WIDTH-2:0], 1'b0};
    end else begin
      if (src[0]) acc_d = {sum, src[WIDTH-1:1]};
      else        acc_d = {1'b0, src[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc_q <= acc_d;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: single-cycle ALU ops complete in one cycle,
// MUL/DIV run WIDTH cycles on muldiv_iter while issue is held off.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);

  seq_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             dz_q, ill_q;

  logic             accept, dz, go_run;
  logic [WIDTH-1:0] sc_lo, sc_hi, md_hi, md_lo;

  assign op_ready = (state_q != RUN);
  assign accept   = op_valid && op_ready && !flush;
  assign dz       = (op_code == ALU_DIV) && (op_b == '0);
  assign go_run   = accept && is_multicycle(op_code) && !dz;

  always_comb begin
    sc_lo = '0;
    sc_hi = '0;
    case (op_code)
      ALU_ADD: sc_lo = op_a + op_b;
      ALU_SUB: sc_lo = op_a - op_b;
      ALU_AND: sc_lo = op_a & op_b;
      ALU_OR:  sc_lo = op_a | op_b;
      ALU_NOR: sc_lo = ~(op_a | op_b);
      ALU_SLT: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_XOR: sc_lo = op_a ^ op_b;
      ALU_DIV: begin
        sc_lo = '1;
        sc_hi = op_a;
      end
      default: ;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (go_run),
    .is_div (op_code == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .step   ((state_q == RUN) && (cnt_q != '0)),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q     <= DONE;
            result_q    <= md_lo;
            result_hi_q <= md_hi;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          if (go_run) begin
            state_q <= RUN;
            cnt_q   <= CW'(WIDTH-1);
          end else if (accept) begin
            state_q     <= DONE;
            result_q    <= sc_lo;
            result_hi_q <= sc_hi;
            dz_q        <= dz;
            ill_q       <= is_illegal(op_code);
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign res_valid   = (state_q == DONE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign div_by_zero = dz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl at WIDTH=32; inputs driven and outputs sampled on negedge.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, op_valid, op_ready, flush, res_valid, div_by_zero, illegal_op;
  logic [3:0]   op_code;
  logic [W-1:0] op_a, op_b, result, result_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .flush(flush),
    .res_valid(res_valid), .result(result), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  // drive one op for one cycle; returns in the negedge of cycle T+1 with operands scrambled
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0; op_code = 4'hA; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op_code = ALU_NOP; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({op_ready, res_valid, div_by_zero, illegal_op} !== 4'b1000) begin
      fails++; $display("FAIL reset_ctrl got %b want 1000", {op_ready, res_valid, div_by_zero, illegal_op});
    end
    tests++;
    if (result !== '0 || result_hi !== '0) begin
      fails++; $display("FAIL reset_data got %h/%h want 0/0", result, result_hi);
    end
  endtask

  task automatic test_add;
    issue(ALU_ADD, 32'd5, 32'd7);
    tests++;
    if (res_valid !== 1'b1 || result !== 32'd12 || result_hi !== '0) begin
      fails++; $display("FAIL add got v=%b %h/%h want 1 0000000c/0", res_valid, result, result_hi);
    end
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0) begin
      fails++; $display("FAIL add_pulse got v=%b want 0", res_valid);
    end
  endtask

  task automatic run_md(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int bad;
    issue(c, a, b);
    bad = 0;
    for (int i = 1; i <= W; i++) begin
      if (op_ready !== 1'b0 || res_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL %s_run got %0d bad cycles want 0", nm, bad);
    end
    tests++;
    if (res_valid !== 1'b1 || op_ready !== 1'b1) begin
      fails++; $display("FAIL %s_done got v=%b r=%b want 1 1", nm, res_valid, op_ready);
    end
    tests++;
    if (result !== elo || result_hi !== ehi || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL %s_data got %h/%h dz=%b want %h/%h 0", nm, result, result_hi, div_by_zero, elo, ehi);
    end
  endtask

  task automatic test_mul;
    run_md("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1);
  endtask

  task automatic test_div;
    run_md("div", ALU_DIV, 32'd100, 32'd7, 32'd14, 32'd2);
    issue(ALU_DIV, 32'd5, 32'd0);
    tests++;
    if (res_valid !== 1'b1 || result !== 32'hFFFF_FFFF || result_hi !== 32'd5 || div_by_zero !== 1'b1) begin
      fails++; $display("FAIL div0 got v=%b %h/%h dz=%b want 1 ffffffff/5 1", res_valid, result, result_hi, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]   c [4] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR};
    logic [W-1:0] a [4] = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'hF0};
    logic [W-1:0] b [4] = '{32'd1, 32'd1, 32'd1, 32'hFF};
    logic [W-1:0] e [4] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h0F};
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if (res_valid !== 1'b1 || result !== e[i-1] || div_by_zero !== 1'b0) begin
          fails++; $display("FAIL b2b_%0d got v=%b %h dz=%b want 1 %h 0", i-1, res_valid, result, div_by_zero, e[i-1]);
        end
      end
      if (i < 4) begin
        op_valid = 1'b1; op_code = c[i]; op_a = a[i]; op_b = b[i];
      end else begin
        op_valid = 1'b0;
      end
    end
  endtask

  task automatic test_flush;
    int seen;
    issue(ALU_MUL, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (op_ready !== 1'b1) begin
      fails++; $display("FAIL flush_ready got %b want 1", op_ready);
    end
    seen = 0;
    for (int i = 11; i <= 40; i++) begin
      if (res_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL flush_novalid got %0d pulses want 0", seen);
    end
    tests++;
    if (result !== 32'h0F || result_hi !== '0) begin
      fails++; $display("FAIL flush_hold got %h/%h want 0000000f/0", result, result_hi);
    end
    issue(ALU_MUL, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || result_hi !== '0) begin
      fails++; $display("FAIL rst_mid got r=%b v=%b %h/%h want 1 0 0/0", op_ready, res_valid, result, result_hi);
    end
  endtask

  task automatic test_illegal;
    issue(4'b1111, 32'd1, 32'd2);
    tests++;
    if (res_valid !== 1'b1 || illegal_op !== 1'b1 || result !== '0 || result_hi !== '0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL illegal got v=%b ill=%b %h/%h want 1 1 0/0", res_valid, illegal_op, result, result_hi);
    end
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; op_code = ALU_ADD; op_a = 32'd5; op_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1 || result !== '0) begin
      fails++; $display("FAIL flush_accept got v=%b r=%b %h want 0 1 0", res_valid, op_ready, result);
    end
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0) begin
      fails++; $display("FAIL flush_accept2 got v=%b want 0", res_valid);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_back_to_back;
    test_flush;
    test_illegal;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
